// File: rtl/game_pkg.sv
// Shared game constants: screen codes, geometry and start-button hitbox.
// Imported by the game sequencer and the screen multiplexer.
package game_pkg;

    localparam logic [1:0] SCR_START = 2'd0;
    localparam logic [1:0] SCR_PLAY  = 2'd1;
    localparam logic [1:0] SCR_OVER  = 2'd2;

    typedef enum logic [1:0] {
        ST_START = SCR_START,
        ST_PLAY  = SCR_PLAY,
        ST_OVER  = SCR_OVER
    } state_t;

    localparam int SCREEN_WIDTH  = 1024;
    localparam int SCREEN_HEIGHT = 768;
    localparam int PIC_WIDTH     = 54;
    localparam int PIC_HEIGHT    = 53;

    // Centred icon origin, rounded up: 485, 358
    localparam int H_COORD = (SCREEN_WIDTH - PIC_WIDTH + 1) / 2;
    localparam int V_COORD = (SCREEN_HEIGHT - PIC_HEIGHT + 1) / 2;

    function automatic logic in_start_btn(
        input logic [11:0] x,
        input logic [11:0] y
    );
        return (x >= 12'(H_COORD))
            && (x <  12'(H_COORD + PIC_WIDTH))
            && (y >= 12'(V_COORD))
            && (y <  12'(V_COORD + PIC_HEIGHT));
    endfunction

endpackage

// File: rtl/game_ctrl_rise.sv
// Rising-edge detector: one-cycle pulse when the input goes high.
// Input is assumed already synchronous to pclk.
module rise_detect (
    input  logic pclk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Register the previous input level
    always_ff @(posedge pclk) begin
        if (rst) in_q <= 1'b0;
        else     in_q <= in;
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer: START -> PLAY -> OVER, countdown and score.
// Screen code is committed only on frame ticks.
module game_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int GAME_TIME      = 30,
    parameter int OVER_HOLD      = 120
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        vsync,
    input  logic        hit,
    output logic [1:0]  screen_sel,
    output logic        game_active,
    output logic [7:0]  time_left,
    output logic [7:0]  score
);

    localparam int FC_W   = $clog2(FRAMES_PER_SEC + 1);
    localparam int HOLD_W = (OVER_HOLD < 1) ? 1 : $clog2(OVER_HOLD + 1);

    state_t            state;
    state_t            state_nxt;
    logic [FC_W-1:0]   frame_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        sel_pend;
    logic              click;
    logic              tick;
    logic              sec_wrap;
    logic              hold_done;

    rise_detect u_click (
        .pclk  (pclk),
        .rst   (rst),
        .in    (mouse_left),
        .pulse (click)
    );

    rise_detect u_tick (
        .pclk  (pclk),
        .rst   (rst),
        .in    (vsync),
        .pulse (tick)
    );

    assign sel_pend  = state;
    assign sec_wrap  = (frame_cnt == FC_W'(FRAMES_PER_SEC - 1));
    assign hold_done = (hold_cnt == HOLD_W'(OVER_HOLD));

    // Next-state decode from clicks, countdown expiry and OVER hold
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_START:
                if (click && in_start_btn(xpos, ypos))
                    state_nxt = ST_PLAY;
            ST_PLAY:
                if (tick && sec_wrap && time_left <= 8'd1)
                    state_nxt = ST_OVER;
            ST_OVER:
                if (click && hold_done)
                    state_nxt = ST_START;
            default:
                state_nxt = ST_START;
        endcase
    end

    // State, counters, score and the frame-aligned screen commit
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= ST_START;
            screen_sel  <= SCR_START;
            game_active <= 1'b0;
            time_left   <= 8'd0;
            score       <= 8'd0;
            frame_cnt   <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            game_active <= (state_nxt == ST_PLAY);
            if (tick)
                screen_sel <= sel_pend;
            unique case (state)
                ST_START: begin
                    if (state_nxt == ST_PLAY) begin
                        time_left <= 8'(GAME_TIME);
                        score     <= 8'd0;
                        frame_cnt <= '0;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (sec_wrap) begin
                            frame_cnt <= '0;
                            if (time_left != 8'd0)
                                time_left <= time_left - 8'd1;
                            if (state_nxt == ST_OVER)
                                hold_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    if (hit && score != 8'hFF)
                        score <= score + 8'd1;
                end
                ST_OVER: begin
                    if (tick && !hold_done)
                        hold_cnt <= hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: scoreboard of expected outputs, vsync every 20 cycles.
// Small parameters so whole rounds fit in a short run.
module tb_game_ctrl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        vsync;
    logic        hit;
    logic [1:0]  screen_sel;
    logic        game_active;
    logic [7:0]  time_left;
    logic [7:0]  score;

    logic        vs_en;
    logic        vs_d;
    logic        tick_now;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       act;
        logic [7:0] tl;
        logic [7:0] sc;
    } exp_t;

    exp_t sb[$];

    game_ctrl #(
        .FRAMES_PER_SEC (2),
        .GAME_TIME      (3),
        .OVER_HOLD      (2)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .mouse_left  (mouse_left),
        .xpos        (xpos),
        .ypos        (ypos),
        .vsync       (vsync),
        .hit         (hit),
        .screen_sel  (screen_sel),
        .game_active (game_active),
        .time_left   (time_left),
        .score       (score)
    );

    always #5 pclk = ~pclk;

    // vsync high 2 cycles of every 20; tick_now marks the DUT's tick edge ahead
    initial begin
        vsync    = 1'b0;
        vs_d     = 1'b0;
        tick_now = 1'b0;
        cyc      = 0;
        forever begin
            @(posedge pclk);
            #1;
            vs_d     = vsync;
            vsync    = vs_en && ((cyc % 20) < 2);
            tick_now = vsync && !vs_d;
            cyc++;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic [1:0] sel,
                              input logic act,
                              input logic [7:0] tl,
                              input logic [7:0] sc);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.act = act;
        e.tl  = tl;
        e.sc  = sc;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".sel"},   32'(screen_sel),  32'(e.sel));
        chk({e.tag, ".act"},   32'(game_active), 32'(e.act));
        chk({e.tag, ".tleft"}, 32'(time_left),   32'(e.tl));
        chk({e.tag, ".score"}, 32'(score),       32'(e.sc));
    endtask

    // Wait for the next frame tick edge; optionally pulse hit in that cycle
    task automatic wait_tick(input logic h);
        int n;
        n = 0;
        while (!tick_now && n < 60) begin
            @(negedge pclk);
            n++;
        end
        if (!tick_now) begin
            chk("tick_timeout", 32'd1, 32'd0);
        end else begin
            hit = h;
            @(negedge pclk);
            hit = 1'b0;
        end
    endtask

    task automatic click(input logic [11:0] x, input logic [11:0] y);
        xpos       = x;
        ypos       = y;
        mouse_left = 1'b1;
        @(negedge pclk);
        mouse_left = 1'b0;
        @(negedge pclk);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        mouse_left = 1'b0;
        xpos       = '0;
        ypos       = '0;
        hit        = 1'b0;
        vs_en      = 1'b1;
        repeat (3) @(negedge pclk);
        rst = 1'b0;

        expect_out("idle", 2'd0, 1'b0, 8'd0, 8'd0);
        repeat (100) @(negedge pclk);
        compare_out();

        expect_out("sync0", 2'd0, 1'b0, 8'd0, 8'd0);
        wait_tick(1'b0);
        compare_out();

        expect_out("miss_x", 2'd0, 1'b0, 8'd0, 8'd0);
        click(12'd484, 12'd380);
        compare_out();

        expect_out("miss_y", 2'd0, 1'b0, 8'd0, 8'd0);
        click(12'd500, 12'd411);
        compare_out();

        expect_out("start", 2'd0, 1'b1, 8'd3, 8'd0);
        click(12'd500, 12'd380);
        compare_out();

        expect_out("tick1", 2'd1, 1'b1, 8'd3, 8'd0);
        wait_tick(1'b0);
        compare_out();

        expect_out("hits5", 2'd1, 1'b1, 8'd3, 8'd5);
        repeat (5) begin
            hit = 1'b1;
            @(negedge pclk);
            hit = 1'b0;
            @(negedge pclk);
        end
        compare_out();

        expect_out("tick2", 2'd1, 1'b1, 8'd2, 8'd6);
        wait_tick(1'b1);
        compare_out();

        expect_out("tick3", 2'd1, 1'b1, 8'd2, 8'd6);
        wait_tick(1'b0);
        compare_out();

        expect_out("play_clk", 2'd1, 1'b1, 8'd2, 8'd6);
        click(12'd500, 12'd380);
        compare_out();

        expect_out("tick4", 2'd1, 1'b1, 8'd1, 8'd6);
        wait_tick(1'b0);
        compare_out();

        expect_out("tick5", 2'd1, 1'b1, 8'd1, 8'd6);
        wait_tick(1'b0);
        compare_out();

        expect_out("tick6", 2'd1, 1'b0, 8'd0, 8'd7);
        wait_tick(1'b1);
        compare_out();

        expect_out("tick7", 2'd2, 1'b0, 8'd0, 8'd7);
        wait_tick(1'b0);
        compare_out();

        expect_out("hold_clk", 2'd2, 1'b0, 8'd0, 8'd7);
        click(12'd10, 12'd10);
        compare_out();

        expect_out("tick8", 2'd2, 1'b0, 8'd0, 8'd7);
        wait_tick(1'b0);
        compare_out();

        expect_out("held", 2'd0, 1'b0, 8'd0, 8'd7);
        xpos       = 12'd500;
        ypos       = 12'd380;
        mouse_left = 1'b1;
        repeat (30) @(negedge pclk);
        mouse_left = 1'b0;
        compare_out();

        expect_out("back", 2'd0, 1'b0, 8'd0, 8'd7);
        wait_tick(1'b0);
        compare_out();

        expect_out("start2", 2'd0, 1'b1, 8'd3, 8'd0);
        click(12'd538, 12'd410);
        compare_out();

        expect_out("sat", 2'd0, 1'b1, 8'd3, 8'd255);
        vs_en = 1'b0;
        hit   = 1'b1;
        repeat (300) @(negedge pclk);
        hit = 1'b0;
        compare_out();

        vs_en = 1'b1;
        expect_out("r2_t1", 2'd1, 1'b1, 8'd3, 8'd255);
        wait_tick(1'b0);
        compare_out();

        expect_out("r2_t2", 2'd1, 1'b1, 8'd2, 8'd255);
        wait_tick(1'b0);
        compare_out();

        expect_out("reset", 2'd0, 1'b0, 8'd0, 8'd0);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        compare_out();

        expect_out("start3", 2'd0, 1'b1, 8'd3, 8'd0);
        click(12'd485, 12'd358);
        compare_out();

        expect_out("r3_t1", 2'd1, 1'b1, 8'd3, 8'd0);
        wait_tick(1'b0);
        compare_out();

        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-level sequencer for the bug-catching VGA design. It owns the START → PLAY → OVER flow, decodes mouse clicks on the start button, and runs the round countdown and score. It drives the screen-select code that the downstream screen multiplexer uses to pick between the start, game and game-over pixel streams. Screen changes are committed only on frame boundaries, so the display never switches mid-frame.

## Interface
Parameters:
- FRAMES_PER_SEC, 60, frame ticks per countdown second
- GAME_TIME, 30, round length in seconds (1..255)
- OVER_HOLD, 120, frames the OVER screen ignores clicks

Ports:
- pclk  in  1  pixel clock; sole clock
- rst  in  1  reset, synchronous, active-high
- mouse_left  in  1  left button level, already synchronous to pclk
- xpos  in  12  mouse x, pixels
- ypos  in  12  mouse y, pixels
- vsync  in  1  vertical sync from the timing chain, active-high
- hit  in  1  one-cycle pulse when the player catches the bug
- screen_sel  out  2  committed screen code: 0 START, 1 PLAY, 2 OVER
- game_active  out  1  high while the state is PLAY
- time_left  out  8  seconds remaining
- score  out  8  hits this round, saturating

## Operation
- Click event: mouse_left is high while its registered copy is low. The event lasts one cycle; holding the button produces no further events.
- Frame tick: vsync is high while its registered copy is low. There is one tick per frame.
- Start button hitbox (1024×768 screen, 54×53 icon):
  - 485 ≤ xpos < 539
  - 358 ≤ ypos < 411
  - Bounds are inclusive-low, exclusive-high, compared unsigned in 12 bits.
- START state:
  - A click inside the hitbox moves to PLAY.
  - On that transition: time_left ← GAME_TIME, score ← 0, frame_cnt ← 0.
  - Clicks outside the hitbox are ignored.
- PLAY state:
  - Each frame tick increments frame_cnt.
  - At FRAMES_PER_SEC-1, frame_cnt wraps to 0 and time_left decrements.
  - When time_left reaches 0 on a wrap: move to OVER and clear hold_cnt.
  - hit increments score, saturating at 255.
  - A hit in the cycle of the final decrement still counts.
  - Clicks are ignored.
- OVER state:
  - Each frame tick increments hold_cnt, saturating at OVER_HOLD.
  - Once hold_cnt == OVER_HOLD, a click anywhere moves to START.
  - score and time_left keep their values until the next PLAY entry.
  - hit is ignored.
- Screen commit: sel_pend tracks the state encoding. screen_sel ← sel_pend on each frame tick.
- A START→PLAY→… sequence completing within one frame is not reachable, because PLAY lasts at least 1 s.

## Timing
- Reset values:
  - state START, screen_sel 0, game_active 0
  - time_left 0, score 0
  - frame_cnt 0, hold_cnt 0
  - both edge registers 0
- All outputs are registered.
- Click latency: with mouse_left first high at cycle N, state and game_active update at edge N+1.
- Screen latency: screen_sel follows the state at the first frame tick after the state changes. That is one cycle after the tick edge, and at most one frame late.
- Frame tick and state change in the same cycle: the tick commits the old sel_pend; the new code commits at the next tick.
- hit in the same cycle as a second decrement: both apply.
- rst asserted mid-round returns every register to its reset value at the next edge; any pending commit is dropped.

## Structure
- Shared package game_pkg holds:
  - screen codes SCR_START=0, SCR_PLAY=1, SCR_OVER=2
  - SCREEN_WIDTH/HEIGHT, PIC_WIDTH/HEIGHT
  - derived H_COORD/V_COORD, which the screen multiplexer also uses
- Sub-module rise_detect (pclk, rst, in → pulse) is instantiated twice, once for mouse_left and once for vsync.
- Main FSM: one case-based next-state block plus one clocked block.

## Test plan
Bench parameters: FRAMES_PER_SEC=2, GAME_TIME=3, OVER_HOLD=2; vsync pulsed every 20 cycles.
- Reset, then idle 100 cycles → screen_sel=0, game_active=0, score=0, time_left=0.
- Click at (500,380) → game_active=1 next cycle; time_left=3; screen_sel=1 one cycle after the next vsync rise. Click at (484,380) or (500,411) → no change.
- In PLAY, 6 frame ticks → time_left goes 2, 1, 0 on ticks 2, 4, 6; state OVER after tick 6; screen_sel=2 after tick 7.
- 300 hit pulses during PLAY → score=255 (saturation). A hit coincident with the final decrement → counted.
- In OVER, click before the second frame tick → ignored. Click after it → START, with score retained. A held button gives exactly one transition.
- rst for one cycle mid-PLAY with time_left=2 → all outputs at reset values the next cycle; a START click still works afterwards.
